// File: rtl/rst_pkg.sv
// Shared constants, FSM state type and table geometry for substitute_stream.
package rst_pkg;

  localparam logic [7:0] CH_NUL = 8'h00;
  localparam logic [7:0] CH_LA  = 8'h61;
  localparam logic [7:0] CH_LZ  = 8'h7a;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_UA  = 8'h41;
  localparam logic [7:0] CH_UZ  = 8'h5a;

  localparam int unsigned TABLE_DIM = 7;

  typedef enum logic [1:0] {
    IDLE,
    EMIT_ROW,
    EMIT_COL
  } state_e;

endpackage

// File: rtl/char_to_coord.sv
// Plaintext char -> substitution table coordinates (r,c in 1..6).
// Optional SUBST_UPPER_FOLD_EN folds 'A'..'Z' onto 'a'..'z' before mapping.
module char_to_coord
  import rst_pkg::*;
(
  input  logic [7:0] ch,
  output logic       valid,
  output logic [2:0] r,
  output logic [2:0] c
);

  logic [7:0] ch_f;
  logic [7:0] idx;

  always_comb begin
    ch_f = ch;
`ifdef SUBST_UPPER_FOLD_EN
    if (ch >= CH_UA && ch <= CH_UZ) ch_f = ch + 8'h20;
`endif
    valid = 1'b0;
    idx   = '0;
    if (ch_f >= CH_LA && ch_f <= CH_LZ) begin
      valid = 1'b1;
      idx   = ch_f - CH_LA;
    end else if (ch_f >= CH_0 && ch_f <= CH_9) begin
      valid = 1'b1;
      idx   = ch_f - CH_0 + 8'd26;
    end
    r = 3'(idx / 8'd6 + 8'd1);
    c = 3'(idx % 8'd6 + 8'd1);
  end

endmodule

// File: rtl/substitute_stream.sv
// Substitutes each plaintext char with its row/column header pair from sub_char.
// Build option: SUBST_UPPER_FOLD_EN (see char_to_coord).
module substitute_stream
  import rst_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0][6:0][7:0] sub_char,
  input  logic                 table_ok,
  input  logic                 ptxt_valid,
  input  logic [7:0]           ptxt_char,
  output logic                 ptxt_ready,
  output logic                 ctxt_valid,
  output logic [7:0]           ctxt_char,
  input  logic                 ctxt_ready,
  output logic                 err_invalid_ptxt_char
);

  state_e     state_q, state_d;
  logic [7:0] row_hdr_q, row_hdr_d;
  logic [7:0] col_hdr_q, col_hdr_d;
  logic       err_q, err_d;

  logic       cc_valid;
  logic [2:0] cc_r;
  logic [2:0] cc_c;

  char_to_coord u_coord (
    .ch    (ptxt_char),
    .valid (cc_valid),
    .r     (cc_r),
    .c     (cc_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_hdr_q <= CH_NUL;
      col_hdr_q <= CH_NUL;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_hdr_q <= row_hdr_d;
      col_hdr_q <= col_hdr_d;
      err_q     <= err_d;
    end
  end

  // Headers are captured at the transfer so later table changes cannot leak into a pair.
  always_comb begin
    state_d    = state_q;
    row_hdr_d  = row_hdr_q;
    col_hdr_d  = col_hdr_q;
    err_d      = 1'b0;
    ptxt_ready = 1'b0;
    ctxt_valid = 1'b0;
    ctxt_char  = CH_NUL;
    unique case (state_q)
      IDLE: begin
        ptxt_ready = table_ok & rst_n;
        if (ptxt_valid && ptxt_ready) begin
          if (cc_valid) begin
            row_hdr_d = sub_char[cc_r][0];
            col_hdr_d = sub_char[0][cc_c];
            state_d   = EMIT_ROW;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EMIT_ROW: begin
        ctxt_valid = 1'b1;
        ctxt_char  = row_hdr_q;
        if (ctxt_ready) state_d = EMIT_COL;
      end
      EMIT_COL: begin
        ctxt_valid = 1'b1;
        ctxt_char  = col_hdr_q;
        if (ctxt_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_invalid_ptxt_char = err_q;

endmodule

// File: tb/tb_substitute_stream.sv
// Self-checking bench for substitute_stream: queue-based reference model plus directed literal checks.
module tb_substitute_stream;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [6:0][6:0][7:0] sub_char;
  logic                 table_ok;
  logic                 ptxt_valid;
  logic [7:0]           ptxt_char;
  logic                 ptxt_ready;
  logic                 ctxt_valid;
  logic [7:0]           ctxt_char;
  logic                 ctxt_ready;
  logic                 err_invalid_ptxt_char;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] out_log[$];
  bit         err_exp = 1'b0;

  string ROWS = "AKCIEG";
  string COLS = "BLDJFH";

  always #5 clk = ~clk;

  substitute_stream dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .sub_char              (sub_char),
    .table_ok              (table_ok),
    .ptxt_valid            (ptxt_valid),
    .ptxt_char             (ptxt_char),
    .ptxt_ready            (ptxt_ready),
    .ctxt_valid            (ctxt_valid),
    .ctxt_char             (ctxt_char),
    .ctxt_ready            (ctxt_ready),
    .err_invalid_ptxt_char (err_invalid_ptxt_char)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a char becomes the pair (row letter, column letter) of its 0..35 index in a 6x6 grid.
  function automatic bit model(input logic [7:0] ch, output logic [7:0] rc, output logic [7:0] cc);
    int v = int'(ch);
    int idx;
`ifdef SUBST_UPPER_FOLD_EN
    if (v >= 65 && v <= 90) v = v + 32;
`endif
    rc = 8'h00;
    cc = 8'h00;
    if (v >= 97 && v <= 122) idx = v - 97;
    else if (v >= 48 && v <= 57) idx = 26 + v - 48;
    else return 1'b0;
    rc = ROWS[idx / 6];
    cc = COLS[idx % 6];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    logic [7:0] rc, cc;
    if (chk_en) begin
      chk("m_ptxt_ready", 32'(ptxt_ready), 32'(rst_n && table_ok && exp_q.size() == 0));
      chk("m_ctxt_valid", 32'(ctxt_valid), 32'(exp_q.size() != 0));
      chk("m_ctxt_char", 32'(ctxt_char), 32'(exp_q.size() != 0 ? exp_q[0] : 8'h00));
      chk("m_err", 32'(err_invalid_ptxt_char), 32'(err_exp));
      err_exp = 1'b0;
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        if (ctxt_valid && ctxt_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          out_log.push_back(ctxt_char);
        end
        if (ptxt_valid && ptxt_ready) begin
          if (model(ptxt_char, rc, cc)) begin
            exp_q.push_back(rc);
            exp_q.push_back(cc);
          end else begin
            err_exp = 1'b1;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] ch);
    int n = 0;
    ptxt_valid = 1'b1;
    ptxt_char  = ch;
    @(negedge clk);
    while (!ptxt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ptxt_ready) begin
      errors++;
      $display("FAIL send_timeout char=%h", ch);
    end
    @(posedge clk);
    #1 ptxt_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (ctxt_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ctxt_valid) begin
      errors++;
      $display("FAIL idle_timeout ctxt_valid=%b", ctxt_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string name, input string s);
    chk({name, "_len"}, 32'(out_log.size()), 32'(s.len()));
    for (int i = 0; i < s.len() && i < out_log.size(); i++)
      chk(name, 32'(out_log[i]), 32'(s[i]));
  endtask

  task automatic init_table();
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        sub_char[r][c] = 8'(8'h60 + r * 7 + c);
    sub_char[0][0] = 8'h00;
    for (int i = 1; i <= 6; i++) begin
      sub_char[i][0] = ROWS[i-1];
      sub_char[0][i] = COLS[i-1];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; table_ok = 1'b1; ptxt_valid = 1'b0; ptxt_char = 8'h00; ctxt_ready = 1'b1;
    init_table();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ptxt_ready", 32'(ptxt_ready), 32'd0);
    chk("rst_ctxt_valid", 32'(ctxt_valid), 32'd0);
    chk("rst_ctxt_char", 32'(ctxt_char), 32'h00);
    chk("rst_err", 32'(err_invalid_ptxt_char), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // 'a' -> A then B, ready again two cycles later
    send(8'h61);
    @(negedge clk);
    chk("a_row_valid", 32'(ctxt_valid), 32'd1);
    chk("a_row", 32'(ctxt_char), 32'h41);
    @(negedge clk);
    chk("a_col", 32'(ctxt_char), 32'h42);
    @(negedge clk);
    chk("a_ready_back", 32'(ptxt_ready), 32'd1);
    @(posedge clk); #1;

    // 'z','9' -> E L G H
    out_log.delete();
    send(8'h7a);
    wait_idle();
    send(8'h39);
    wait_idle();
    chk_log("z9_seq", "ELGH");

    // 'h' with back-pressure; headers/table_ok disturbed while the pair is pending
    out_log.delete();
    ctxt_ready = 1'b0;
    send(8'h68);
    sub_char[2][0] = 8'h3f;
    sub_char[0][2] = 8'h3f;
    table_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("h_hold_char", 32'(ctxt_char), 32'h4b);
      chk("h_hold_ready", 32'(ptxt_ready), 32'd0);
    end
    @(posedge clk);
    #1 ctxt_ready = 1'b1;
    @(negedge clk);
    chk("h_row", 32'(ctxt_char), 32'h4b);
    @(negedge clk);
    chk("h_col", 32'(ctxt_char), 32'h4c);
    chk("h_col_ready", 32'(ptxt_ready), 32'd0);
    wait_idle();
    chk_log("h_seq", "KL");
    init_table();
    table_ok = 1'b1;

    // '#' is rejected with a single pulse, then 'a' works normally
    send(8'h23);
    @(negedge clk);
    chk("hash_err", 32'(err_invalid_ptxt_char), 32'd1);
    chk("hash_no_valid", 32'(ctxt_valid), 32'd0);
    @(negedge clk);
    chk("hash_err_clear", 32'(err_invalid_ptxt_char), 32'd0);
    @(posedge clk); #1;
    out_log.delete();
    send(8'h61);
    wait_idle();
    chk_log("after_err_seq", "AB");

    // 'Q': folded to 'q' (C,F) or rejected
    out_log.delete();
    send(8'h51);
`ifdef SUBST_UPPER_FOLD_EN
    wait_idle();
    chk_log("Q_seq", "CF");
`else
    @(negedge clk);
    chk("Q_err", 32'(err_invalid_ptxt_char), 32'd1);
    chk("Q_no_valid", 32'(ctxt_valid), 32'd0);
    @(posedge clk); #1;
`endif

    // reset while the column char is pending
    ctxt_ready = 1'b0;
    send(8'h62);
    @(posedge clk);
    #1 ctxt_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("pre_rst_col", 32'(ctxt_char), 32'h4c);
    @(negedge clk);
    chk("post_rst_valid", 32'(ctxt_valid), 32'd0);
    chk("post_rst_char", 32'(ctxt_char), 32'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    table_ok = 1'b0;
    ptxt_valid = 1'b1;
    ptxt_char = 8'h61;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("tok0_ready", 32'(ptxt_ready), 32'd0);
      chk("tok0_err", 32'(err_invalid_ptxt_char), 32'd0);
    end
    @(posedge clk);
    #1 ptxt_valid = 1'b0;
    table_ok = 1'b1;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
